// File: rtl/window_fifo.sv
// Frame buffer between FIR decimator and FFT; optional almost_full via WINDOW_FIFO_ALMOST_FULL_EN.
// Latency: registered read data valid one cycle after an accepted read; flags registered from next-count.
// Backpressure: writes rejected while full, reads rejected while empty; each rejection sets a sticky flag.
module window_fifo #(
    parameter int DATA_WIDTH = 14,
    parameter int DEPTH      = 1024,
`ifdef WINDOW_FIFO_ALMOST_FULL_EN
    parameter int AF_LEVEL   = DEPTH - 16,
`endif
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wren,
    input  logic signed [DATA_WIDTH-1:0] din,
    input  logic                         rden,
    output logic signed [DATA_WIDTH-1:0] dout,
    output logic                         dout_valid,
    output logic                         dout_last,
    output logic                         full,
    output logic                         empty,
`ifdef WINDOW_FIFO_ALMOST_FULL_EN
    output logic                         almost_full,
`endif
    output logic [CNT_WIDTH-1:0]         count,
    output logic                         overflow,
    output logic                         underflow
);

    logic signed [DATA_WIDTH-1:0] mem [DEPTH];

    logic                         wr_acc, rd_acc;
    logic [ADDR_WIDTH-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_WIDTH-1:0]         count_q, count_d;
    logic                         full_q, full_d, empty_q, empty_d;
    logic                         ovf_q, ovf_d, unf_q, unf_d;
    logic                         vld_q, last_q;
    logic signed [DATA_WIDTH-1:0] dout_q;
`ifdef WINDOW_FIFO_ALMOST_FULL_EN
    logic                         af_q, af_d;
`endif

    // DEPTH need not be a power of two, so wrap explicitly.
    function automatic logic [ADDR_WIDTH-1:0] ptr_inc(input logic [ADDR_WIDTH-1:0] p);
        return (p == ADDR_WIDTH'(DEPTH - 1)) ? '0 : p + ADDR_WIDTH'(1);
    endfunction

    assign wr_acc = wren & ~full_q;
    assign rd_acc = rden & ~empty_q;

    always_comb begin
        wr_ptr_d = wr_acc ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = rd_acc ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CNT_WIDTH'(1);
            2'b01:   count_d = count_q - CNT_WIDTH'(1);
            default: count_d = count_q;
        endcase
        full_d  = (count_d == CNT_WIDTH'(DEPTH));
        empty_d = (count_d == '0);
        ovf_d   = ovf_q | (wren & full_q);
        unf_d   = unf_q | (rden & empty_q);
`ifdef WINDOW_FIFO_ALMOST_FULL_EN
        af_d    = (count_d >= CNT_WIDTH'(AF_LEVEL));
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            vld_q    <= 1'b0;
            last_q   <= 1'b0;
`ifdef WINDOW_FIFO_ALMOST_FULL_EN
            af_q     <= 1'b0;
`endif
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            vld_q    <= rd_acc;
            last_q   <= rd_acc & (count_q == CNT_WIDTH'(1));
`ifdef WINDOW_FIFO_ALMOST_FULL_EN
            af_q     <= af_d;
`endif
        end
    end

    // Storage array kept free of reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr_q] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q <= '0;
        end else if (rd_acc) begin
            dout_q <= mem[rd_ptr_q];
        end
    end

    assign dout       = dout_q;
    assign dout_valid = vld_q;
    assign dout_last  = last_q;
    assign full       = full_q;
    assign empty      = empty_q;
    assign count      = count_q;
    assign overflow   = ovf_q;
    assign underflow  = unf_q;
`ifdef WINDOW_FIFO_ALMOST_FULL_EN
    assign almost_full = af_q;
`endif

endmodule

// File: tb/tb_window_fifo.sv
// Bench for window_fifo at DEPTH=8: constant vector table for fill/overflow/drain/underflow,
// then scoreboard-checked sequences for simultaneous access, wrap, mid-drain reset and random traffic.
module tb_window_fifo;

    localparam int DW    = 14;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int AF    = 6;

    logic                 clk = 1'b0;
    logic                 rst, wren, rden;
    logic signed [DW-1:0] din, dout;
    logic                 dout_valid, dout_last, full, empty, overflow, underflow;
    logic [CW-1:0]        count;
`ifdef WINDOW_FIFO_ALMOST_FULL_EN
    logic                 almost_full;
`endif

    always #5 clk = ~clk;

    window_fifo #(
        .DATA_WIDTH(DW),
`ifdef WINDOW_FIFO_ALMOST_FULL_EN
        .AF_LEVEL(AF),
`endif
        .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .wren(wren), .din(din), .rden(rden),
        .dout(dout), .dout_valid(dout_valid), .dout_last(dout_last),
        .full(full), .empty(empty),
`ifdef WINDOW_FIFO_ALMOST_FULL_EN
        .almost_full(almost_full),
`endif
        .count(count), .overflow(overflow), .underflow(underflow)
    );

    typedef struct {
        logic        rst, wr, rd;
        int          din;
        int          e_cnt;
        logic        e_full, e_empty, e_vld;
        int          e_dout;
        logic        e_last, e_ovf, e_unf;
    } vec_t;

    int errors = 0;
    int checks = 0;

    // Scoreboard model state
    logic [DW-1:0] mq[$];
    logic [DW:0]   expq[$];
    int            mcnt = 0;
    logic          movf = 0, munf = 0, mvld = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic w, input logic rd, input int d);
        logic          wa, ra;
        logic [DW:0]   e;
        @(negedge clk);
        rst = r; wren = w; rden = rd; din = DW'(d);
        @(posedge clk);
        if (r) begin
            mq.delete(); expq.delete();
            mcnt = 0; movf = 0; munf = 0; mvld = 0;
        end else begin
            wa = w && (mcnt != DEPTH);
            ra = rd && (mcnt != 0);
            if (w && mcnt == DEPTH) movf = 1;
            if (rd && mcnt == 0)    munf = 1;
            mvld = ra;
            if (ra) expq.push_back({(mcnt == 1), mq.pop_front()});
            if (wa) mq.push_back(DW'(d));
            mcnt = mq.size();
        end
        #1;
        chk("sb_count", int'(count), mcnt);
        chk("sb_full", int'(full), int'(mcnt == DEPTH));
        chk("sb_empty", int'(empty), int'(mcnt == 0));
        chk("sb_overflow", int'(overflow), int'(movf));
        chk("sb_underflow", int'(underflow), int'(munf));
        chk("sb_valid", int'(dout_valid), int'(mvld));
`ifdef WINDOW_FIFO_ALMOST_FULL_EN
        chk("sb_almost_full", int'(almost_full), int'(mcnt >= AF));
`endif
        if (mvld && expq.size() > 0) begin
            e = expq.pop_front();
            chk("sb_dout", int'(dout), int'(signed'(e[DW-1:0])));
            chk("sb_last", int'(dout_last), int'(e[DW]));
        end else begin
            chk("sb_last_idle", int'(dout_last), 0);
        end
    endtask

    vec_t vec[24];

    initial begin
        rst = 1'b1; wren = 1'b0; rden = 1'b0; din = '0;

        // Fill 1..8, overflow attempt with 99, drain, underflow, reset, underflow from reset
        vec[0] = '{1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 8; i++)
            vec[1+i] = '{1'b0, 1'b1, 1'b0, i + 1, i + 1, (i == 7), 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0};
        vec[9] = '{1'b0, 1'b1, 1'b0, 99, 8, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0};
        for (int j = 0; j < 8; j++)
            vec[10+j] = '{1'b0, 1'b0, 1'b1, 0, 7 - j, 1'b0, (j == 7), 1'b1, j + 1, (j == 7), 1'b1, 1'b0};
        vec[18] = '{1'b0, 1'b0, 1'b1, 0, 0, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b1};
        vec[19] = '{1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0};
        for (int k = 0; k < 3; k++)
            vec[20+k] = '{1'b0, 1'b0, 1'b1, 0, 0, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b1};
        vec[23] = '{1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0};

        for (int n = 0; n < 24; n++) begin
            step(vec[n].rst, vec[n].wr, vec[n].rd, vec[n].din);
            chk("tbl_count", int'(count), vec[n].e_cnt);
            chk("tbl_full", int'(full), int'(vec[n].e_full));
            chk("tbl_empty", int'(empty), int'(vec[n].e_empty));
            chk("tbl_valid", int'(dout_valid), int'(vec[n].e_vld));
            chk("tbl_last", int'(dout_last), int'(vec[n].e_last));
            chk("tbl_overflow", int'(overflow), int'(vec[n].e_ovf));
            chk("tbl_underflow", int'(underflow), int'(vec[n].e_unf));
            if (vec[n].e_vld) chk("tbl_dout", int'(dout), vec[n].e_dout);
        end

        // Steady count of 4 with simultaneous access; pointers wrap past DEPTH-1
        for (int i = 1; i <= 4; i++) step(1'b0, 1'b1, 1'b0, i);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b1, 100 + i);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 0);

        // Full with both strobes: read wins, write rejected
        step(1'b1, 1'b0, 1'b0, 0);
        for (int i = 1; i <= 8; i++) step(1'b0, 1'b1, 1'b0, 40 + i);
        step(1'b0, 1'b1, 1'b1, 77);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b1, 0);

        // Reset in the middle of a drain, then a normal refill/drain
        step(1'b1, 1'b0, 1'b0, 0);
        for (int i = 1; i <= 8; i++) step(1'b0, 1'b1, 1'b0, i);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 0);
        step(1'b1, 1'b0, 1'b1, 0);
        chk("rst_mid_valid", int'(dout_valid), 0);
        chk("rst_mid_count", int'(count), 0);
        for (int i = 1; i <= 8; i++) step(1'b0, 1'b1, 1'b0, 200 + i);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b1, 0);

        // Random traffic including negative samples
        step(1'b1, 1'b0, 1'b0, 0);
        for (int i = 0; i < 300; i++)
            step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, 16383)) - 8192);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
